// File: rtl/sincos_hop_sched_if.sv
// Handshake/bus bundle between the hop scheduler and its controller.
// master drives control and table writes; slave is the scheduler.
interface sincos_hop_sched_if #(
  parameter int unsigned AW = 3
);
  logic          start;
  logic          stop;
  logic [AW-1:0] nch_last;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic [15:0]   get;
  logic          perenos;
  logic          cap_valid;
  logic [AW-1:0] cap_ch;
  logic          cap_first;
  logic          cap_last;
  logic          busy;
  logic          done;
  logic          tbl_wr_err;

  modport master (
    output start, stop, nch_last, tbl_we, tbl_addr, tbl_data,
    input  get, perenos, cap_valid, cap_ch, cap_first, cap_last, busy, done, tbl_wr_err
  );

  modport slave (
    input  start, stop, nch_last, tbl_we, tbl_addr, tbl_data,
    output get, perenos, cap_valid, cap_ch, cap_first, cap_last, busy, done, tbl_wr_err
  );
endinterface

// File: rtl/sincos_hop_sched.sv
// Frequency-hop scheduler: retunes the sincos NCO per table entry, blanks while the
// pipeline refills, then flags a dwell of valid samples. Optional HOP_LOOP_EN: loop forever.
module sincos_hop_sched #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned SETTLE = 64,
  parameter int unsigned DWELL  = 1024,
  parameter int unsigned CW     = 16
) (
  input  logic               clock,
  input  logic               reset,
  sincos_hop_sched_if.slave  bus
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TUNE    = 2'd1,
    S_SETTLE  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   ch, ch_n;
  logic [AW-1:0]   last_q, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   get_q, get_n;
  logic            per_q, per_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            cap_valid_q, cap_valid_n;
  logic            cap_first_q, cap_first_n;
  logic            cap_last_q, cap_last_n;
  logic [AW-1:0]   cap_ch_q, cap_ch_n;
  logic            busy_q, busy_n;

  logic [DW-1:0]   tbl [NCH];

  // Table is writable only while idle; contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.tbl_we && (state == S_IDLE)) begin
      tbl[bus.tbl_addr] <= bus.tbl_data;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    last_n  = last_q;
    cnt_n   = cnt;
    get_n   = get_q;
    per_n   = per_q;
    done_n  = 1'b0;
    err_n   = bus.tbl_we && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = S_TUNE;
          ch_n    = '0;
          cnt_n   = '0;
          last_n  = bus.nch_last;
        end
      end
      S_TUNE: begin
        get_n   = tbl[ch];
        per_n   = 1'b1;
        cnt_n   = '0;
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_n   = '0;
          state_n = S_CAPTURE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        if (cnt == CW'(DWELL - 1)) begin
          cnt_n = '0;
          if (ch < last_q) begin
            ch_n    = ch + AW'(1);
            state_n = S_TUNE;
          end else begin
            done_n = 1'b1;
`ifdef HOP_LOOP_EN
            ch_n    = '0;
            state_n = S_TUNE;
`else
            per_n   = 1'b0;
            state_n = S_IDLE;
`endif
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort overrides any progress made this cycle; the NCO keeps its last increment.
    if ((state != S_IDLE) && bus.stop) begin
      state_n = S_IDLE;
      ch_n    = '0;
      cnt_n   = '0;
      get_n   = get_q;
      per_n   = 1'b0;
      done_n  = 1'b0;
    end

    cap_valid_n = (state_n == S_CAPTURE);
    cap_first_n = cap_valid_n && (cnt_n == '0);
    cap_last_n  = cap_valid_n && (cnt_n == CW'(DWELL - 1));
    cap_ch_n    = cap_valid_n ? ch_n : '0;
    busy_n      = (state_n != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ch          <= '0;
      last_q      <= '0;
      cnt         <= '0;
      get_q       <= '0;
      per_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_first_q <= 1'b0;
      cap_last_q  <= 1'b0;
      cap_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      ch          <= ch_n;
      last_q      <= last_n;
      cnt         <= cnt_n;
      get_q       <= get_n;
      per_q       <= per_n;
      done_q      <= done_n;
      err_q       <= err_n;
      cap_valid_q <= cap_valid_n;
      cap_first_q <= cap_first_n;
      cap_last_q  <= cap_last_n;
      cap_ch_q    <= cap_ch_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.get        = get_q;
  assign bus.perenos    = per_q;
  assign bus.cap_valid  = cap_valid_q;
  assign bus.cap_ch     = cap_ch_q;
  assign bus.cap_first  = cap_first_q;
  assign bus.cap_last   = cap_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.tbl_wr_err = err_q;

endmodule
